// File: rtl/servo_pulse_decoder.sv
// RC-servo pulse decoder: measures pulse high time, converts it to an 8-bit position code, flags glitches/stuck-high/signal loss.
// Optional build macro FAILSAFE_EN: on signal loss, force FAILSAFE_POS onto position with one valid strobe.
module servo_pulse_decoder #(
    parameter int MIN_PULSE_CLKS     = 10000,
    parameter int STEP_CLKS          = 40,
    parameter int GLITCH_CLKS        = 2000,
    parameter int MAX_PULSE_CLKS     = 25000,
    parameter int FRAME_TIMEOUT_CLKS = 250000
`ifdef FAILSAFE_EN
    ,
    parameter int FAILSAFE_POS       = 128
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [7:0] position,
    output logic       valid,
    output logic       signal_ok,
    output logic       pulse_err
);

    localparam logic [15:0] MIN_W      = 16'(MIN_PULSE_CLKS);
    localparam logic [15:0] STEP_LAST  = 16'(STEP_CLKS - 1);
    localparam logic [15:0] GLITCH_W   = 16'(GLITCH_CLKS);
    localparam logic [15:0] MAX_W      = 16'(MAX_PULSE_CLKS);
    localparam logic [23:0] TIMEOUT_C  = 24'(FRAME_TIMEOUT_CLKS);
    localparam logic [23:0] TIMEOUT_M1 = 24'(FRAME_TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        SEEK_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  sync_ff;
    logic        s;
    logic        s_d;
    logic [15:0] width_cnt;
    logic [15:0] step_cnt;
    logic [7:0]  pos_acc;
    logic [23:0] frame_cnt;

    logic rise;
    logic fall;
    logic accept;
    logic glitch;
    logic overlong;
    logic timeout;

    assign s = sync_ff[1];

    // NOTE: the synchroniser is left out of reset so that a pulse already high
    // during reset is seen as high at release and SEEK_LOW can skip it.
    always_ff @(posedge clk) begin
        sync_ff <= {sync_ff[0], pwm_in};
        s_d     <= s;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        rise     = 1'b0;
        fall     = 1'b0;
        accept   = 1'b0;
        glitch   = 1'b0;
        overlong = 1'b0;
        timeout  = 1'b0;
        rise     = s & ~s_d;
        fall     = ~s & s_d;
        if (state == MEASURE) begin
            accept   = fall && (width_cnt >= GLITCH_W);
            glitch   = fall && (width_cnt < GLITCH_W);
            overlong = s && (width_cnt >= MAX_W);
        end
        // A rejected pulse landing on the timeout cycle defers the timeout by one
        // cycle, so valid (failsafe) and pulse_err never coincide.
        timeout = (frame_cnt == TIMEOUT_M1) && !accept && !glitch && !overlong;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEEK_LOW;
            width_cnt <= '0;
            step_cnt  <= '0;
            pos_acc   <= '0;
            frame_cnt <= '0;
            position  <= '0;
            valid     <= 1'b0;
            signal_ok <= 1'b0;
            pulse_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            pulse_err <= 1'b0;

            if (accept) begin
                frame_cnt <= '0;
            end else if (frame_cnt != TIMEOUT_C && !(frame_cnt == TIMEOUT_M1 && (glitch || overlong))) begin
                frame_cnt <= frame_cnt + 24'd1;
            end

            if (timeout) begin
                signal_ok <= 1'b0;
`ifdef FAILSAFE_EN
                position  <= 8'(FAILSAFE_POS);
                valid     <= 1'b1;
`endif
            end

            case (state)
                SEEK_LOW: begin
                    if (!s) state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state     <= MEASURE;
                        width_cnt <= 16'd1;
                        step_cnt  <= '0;
                        pos_acc   <= '0;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        state <= WAIT_RISE;
                        if (glitch) begin
                            pulse_err <= 1'b1;
                        end else begin
                            position  <= pos_acc;
                            valid     <= 1'b1;
                            signal_ok <= 1'b1;
                        end
                    end else if (overlong) begin
                        pulse_err <= 1'b1;
                        state     <= SEEK_LOW;
                    end else begin
                        width_cnt <= width_cnt + 16'd1;
                        // Divider-free scaling: one pos_acc step per STEP_CLKS cycles beyond MIN.
                        if (width_cnt >= MIN_W) begin
                            if (step_cnt == STEP_LAST) begin
                                step_cnt <= '0;
                                if (pos_acc != 8'hFF) pos_acc <= pos_acc + 8'd1;
                            end else begin
                                step_cnt <= step_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: state <= SEEK_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder: table-driven pulse widths plus sequences for reset, overlong, timeout and loopback.
module tb_servo_pulse_decoder;

    localparam int MIN_P   = 100;
    localparam int STEP    = 4;
    localparam int GLITCH  = 20;
    localparam int MAX_P   = 1200;
    localparam int TIMEOUT = 3000;

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [7:0] position;
    logic       valid;
    logic       signal_ok;
    logic       pulse_err;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    servo_pulse_decoder #(
        .MIN_PULSE_CLKS    (MIN_P),
        .STEP_CLKS         (STEP),
        .GLITCH_CLKS       (GLITCH),
        .MAX_PULSE_CLKS    (MAX_P),
        .FRAME_TIMEOUT_CLKS(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pwm_in   (pwm_in),
        .position (position),
        .valid    (valid),
        .signal_ok(signal_ok),
        .pulse_err(pulse_err)
    );

    // Strobe counters, sampled before the edge updates the outputs.
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            if (valid === 1'b1) valid_cnt++;
            if (pulse_err === 1'b1) err_cnt++;
            if (valid === 1'b1 && pulse_err === 1'b1) both_cnt++;
        end
    end

    typedef struct {
        int         width;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_pos;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a pulse of n clk high time; returns on the 3rd negedge after the fall.
    task automatic pulse_and_sample(input int n);
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (n) @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Servo tester model: high time for an 8-bit command.
    function automatic int tester_width(input int cmd);
        return MIN_P + cmd * STEP;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        int e0;

        vecs[0]  = '{612,  1'b1, 1'b0, 8'd128};
        vecs[1]  = '{10,   1'b0, 1'b1, 8'd128};
        vecs[2]  = '{19,   1'b0, 1'b1, 8'd128};
        vecs[3]  = '{20,   1'b1, 1'b0, 8'd0};
        vecs[4]  = '{100,  1'b1, 1'b0, 8'd0};
        vecs[5]  = '{103,  1'b1, 1'b0, 8'd0};
        vecs[6]  = '{104,  1'b1, 1'b0, 8'd1};
        vecs[7]  = '{1119, 1'b1, 1'b0, 8'd254};
        vecs[8]  = '{1120, 1'b1, 1'b0, 8'd255};
        vecs[9]  = '{1150, 1'b1, 1'b0, 8'd255};
        vecs[10] = '{1200, 1'b1, 1'b0, 8'd255};
        vecs[11] = '{612,  1'b1, 1'b0, 8'd128};

        // Reset with the input high, then a partial pulse that must be ignored.
        pwm_in = 1'b1;
        reset  = 1'b1;
        idle(5);
        check("rst_position", 32'(position), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_signal_ok", 32'(signal_ok), 32'd0);
        check("rst_pulse_err", 32'(pulse_err), 32'd0);
        reset = 1'b0;
        idle(50);
        pwm_in = 1'b0;
        idle(20);
        check("partial_no_valid", 32'(valid_cnt), 32'd0);
        check("partial_no_err", 32'(err_cnt), 32'd0);

        @(negedge clk);
        pwm_in = 1'b1;
        repeat (612) @(negedge clk);
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        check("first_valid_early", 32'(valid), 32'd0);
        @(negedge clk);
        check("first_valid", 32'(valid), 32'd1);
        check("first_position", 32'(position), 32'd128);
        check("first_signal_ok", 32'(signal_ok), 32'd1);
        idle(200);

        // Width sweep, glitch rejection and boundary widths.
        for (int i = 0; i < 12; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            pulse_and_sample(vecs[i].width);
            check($sformatf("vec%0d_w%0d_valid", i, vecs[i].width), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_w%0d_err", i, vecs[i].width), 32'(pulse_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_w%0d_pos", i, vecs[i].width), 32'(position), 32'(vecs[i].exp_pos));
            idle(200);
            check($sformatf("vec%0d_valid_count", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err_count", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
        end

        // Stuck-high input: error strobe when W reaches MAX+1, no update on the late fall.
        v0 = valid_cnt;
        e0 = err_cnt;
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (1202) @(negedge clk);
        check("ovl_err_early", 32'(pulse_err), 32'd0);
        @(negedge clk);
        check("ovl_err_strobe", 32'(pulse_err), 32'd1);
        repeat (1500 - 1203) @(negedge clk);
        pwm_in = 1'b0;
        idle(50);
        check("ovl_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("ovl_err_count", 32'(err_cnt - e0), 32'd1);
        check("ovl_pos_held", 32'(position), 32'd128);
        pulse_and_sample(612);
        check("ovl_recover_valid", 32'(valid), 32'd1);
        check("ovl_recover_pos", 32'(position), 32'd128);
        idle(100);

        // Loss of signal: timeout exactly TIMEOUT cycles after the last accepted pulse.
        pulse_and_sample(1120);
        check("to_last_pos", 32'(position), 32'd255);
        idle(TIMEOUT - 1);
        check("to_signal_ok_before", 32'(signal_ok), 32'd1);
        v0 = valid_cnt;
        @(negedge clk);
        check("to_signal_ok_lost", 32'(signal_ok), 32'd0);
`ifdef FAILSAFE_EN
        check("to_failsafe_pos", 32'(position), 32'd128);
        check("to_failsafe_valid", 32'(valid), 32'd1);
        idle(50);
        check("to_valid_count", 32'(valid_cnt - v0), 32'd1);
`else
        check("to_pos_held", 32'(position), 32'd255);
        check("to_no_valid", 32'(valid), 32'd0);
        idle(50);
        check("to_valid_count", 32'(valid_cnt - v0), 32'd0);
`endif
        pulse_and_sample(300);
        check("to_restore_signal_ok", 32'(signal_ok), 32'd1);
        check("to_restore_pos", 32'(position), 32'd50);

        // Loopback from the tester model, command 200, three frames of 2000 clk.
        for (int f = 0; f < 3; f++) begin
            pulse_and_sample(tester_width(200));
            check($sformatf("loop%0d_valid", f), 32'(valid), 32'd1);
            check($sformatf("loop%0d_pos_in_range", f), 32'(position >= 8'd199 && position <= 8'd201), 32'd1);
            idle(2000 - tester_width(200) - 3);
        end

        // Reset in the middle of a pulse: the remainder is ignored.
        @(negedge clk);
        pwm_in = 1'b1;
        idle(300);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        v0 = valid_cnt;
        e0 = err_cnt;
        idle(300);
        pwm_in = 1'b0;
        idle(50);
        check("rstmid_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("rstmid_no_err", 32'(err_cnt - e0), 32'd0);
        check("rstmid_pos", 32'(position), 32'd0);
        check("rstmid_signal_ok", 32'(signal_ok), 32'd0);

        check("valid_err_exclusive", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
